my_gate_n: RTL and testbench
============================

# my_gate_n

Parametrised N-input multi-function logic gate with a registered, handshaked output and a built-in exhaustive sweep sequencer. It generalises the two-input AND gate to WIDTH inputs and six selectable functions. The sweep mode drives every input combination through the gate on chip and counts the vectors that yield 1. It sits in the basic-gates lab library as the reusable gate primitive and as a self-checking demo block.

## Interface

Parameters:
- WIDTH, 4, number of gate inputs; legal range 2..8.

Ports:
- clk  in  1  rising-edge clock; one clock domain only.
- rst  in  1  asynchronous, active-high reset.
- op  in  3  gate function: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110/111 reserved (result 0).
- a  in  WIDTH  operand vector for single-shot mode.
- in_valid  in  1  operand a and op valid this cycle.
- in_ready  out  1  block accepts an operand this cycle.
- sweep_start  in  1  start an exhaustive sweep with the current op.
- x  out  1  gate result.
- vec  out  WIDTH  input vector that produced x.
- out_valid  out  1  x/vec valid.
- out_ready  in  1  downstream accepts x/vec.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse when the last sweep result is accepted.
- ones_cnt  out  WIDTH+1  count of sweep vectors with x=1.

## Operation

- FSM states: IDLE, SWEEP.
  - IDLE -> SWEEP when sweep_start=1.
  - SWEEP -> IDLE when the output handshake completes on vector 2^WIDTH-1.
- Output slot: one register holding x, vec, and an internal last flag.
  - Slot is free when out_valid=0, or when out_valid=1 and out_ready=1.
- Single-shot mode (IDLE):
  - in_ready = free && !sweep_start.
  - On in_valid && in_ready, the slot loads x = f(op, a), vec = a, last = 0.
- Sweep:
  - On entry, the block latches op into op_q, clears counter cnt to 0, and clears ones_cnt to 0.
  - Each cycle the slot is free, the slot loads x = f(op_q, cnt) and vec = cnt; last is set when cnt = 2^WIDTH-1. Then cnt increments.
  - No new vector is issued after the last one.
  - ones_cnt increments by 1 on each sweep output handshake (out_valid && out_ready) with x=1.
  - ones_cnt holds its value after the sweep ends, until the next sweep_start or rst.
- Function rules:
  - AND/OR/XOR are reductions over all WIDTH bits; NAND/NOR/XNOR are their inversions.
  - Reserved op codes give x=0 and are not an error.
- Boundary cases:
  - sweep_start while busy: ignored.
  - sweep_start and in_valid together in IDLE: the sweep wins; in_ready=0 and the operand is not accepted.
  - op changing mid-sweep: no effect (op_q is used).
  - in_valid during a sweep: in_ready=0.
  - Downstream stall (out_ready=0): x/vec/out_valid hold stable and cnt does not advance.
  - cnt is WIDTH+1 bits wide so the terminal compare cannot wrap.
  - rst mid-sweep: everything returns to reset values immediately, any in-flight result is lost, and the FSM goes to IDLE.

## Timing

- Reset values:
  - x=0, vec=0, out_valid=0, busy=0, done=0, ones_cnt=0.
  - in_ready=1 once rst is released (combinational, while IDLE with a free slot and no sweep_start).
- Single-shot latency: an operand accepted at edge N appears with out_valid=1 after edge N.
- Throughput: one result per cycle when out_ready is held at 1.
- Sweep:
  - First vector enters the slot on the edge after the sweep_start edge.
  - With out_ready=1 throughout, the sweep occupies 2^WIDTH+1 cycles from sweep_start to done.
- busy is 1 from the edge after sweep_start up to and including the cycle whose edge completes the last handshake. It returns to 0 in the same cycle done asserts.
- done asserts for exactly one cycle, after the edge that completes the last-vector handshake.
- ones_cnt is final when done asserts.

## Structure

- Shared package gate_pkg holds:
  - op-code constants: OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_XNOR;
  - state encoding: S_IDLE, S_SWEEP.
- Sub-module gate_reduce (purely combinational): inputs op, a[WIDTH-1:0]; output y.
  - Used in both modes.
  - Reusable by later lab blocks.
- Top level contains the FSM, cnt, op_q, the output slot, and ones_cnt.

## Test plan

- Reset: assert rst mid-run -> all outputs 0 immediately; in_ready=1 after release.
- Single shot, WIDTH=4, op=AND, a = 4'b0001, 4'b1110, 4'b1111 back to back with out_ready=1 -> x = 0, 0, 1 on consecutive cycles, with vec echoed each time.
- Sweep, WIDTH=4:
  - op=AND -> 16 results, vec 0..15, x=1 only at vec 15; ones_cnt=1; done 17 cycles after sweep_start.
  - op=XOR -> ones_cnt=8. op=NAND -> ones_cnt=15. op=NOR -> ones_cnt=1.
- Backpressure: during a sweep, toggle out_ready randomly -> vec sequence still exactly 0..15 with no gaps or repeats; outputs stable while stalled; ones_cnt still correct.
- Collisions:
  - sweep_start together with in_valid -> operand not accepted.
  - op changed mid-sweep -> ones_cnt matches the latched op.
  - second sweep_start while busy -> ignored.
  - op=110 single shot -> x=0.

Source files
------------

// File: rtl/gate_pkg.sv
// gate_pkg: shared op codes and FSM state encoding for the gate library
//   OP_*      : 3-bit gate function codes (110/111 reserved, result 0)
//   state_t   : sweep sequencer states
package gate_pkg;
   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_XOR  = 3'b010;
   localparam logic [2:0] OP_NAND = 3'b011;
   localparam logic [2:0] OP_NOR  = 3'b100;
   localparam logic [2:0] OP_XNOR = 3'b101;
   typedef enum logic {S_IDLE, S_SWEEP} state_t;
endpackage

// File: rtl/gate_reduce.sv
// gate_reduce: combinational WIDTH-input multi-function reduction gate
//   op : gate function code
//   a  : operand vector
//   y  : reduced result
module gate_reduce
   import gate_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   output logic             y
);
   always_comb begin
      y = op == OP_AND  ?  &a :
          op == OP_OR   ?  |a :
          op == OP_XOR  ?  ^a :
          op == OP_NAND ? ~&a :
          op == OP_NOR  ? ~|a :
          op == OP_XNOR ? ~^a : 1'b0;
   end
endmodule

// File: rtl/my_gate_n.sv
// my_gate_n: N-input multi-function gate with handshaked output slot and exhaustive sweep
//   clk, rst          : clock, async active-high reset
//   op, a, in_valid   : single-shot operand input, in_ready back-pressure
//   sweep_start       : begin sweep of all 2^WIDTH vectors with current op
//   x, vec, out_valid : registered result slot, accepted by out_ready
//   busy, done        : sweep in progress, one-cycle completion pulse
//   ones_cnt          : number of sweep results equal to 1
module my_gate_n
   import gate_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             sweep_start,
   output logic             x,
   output logic [WIDTH-1:0] vec,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH:0]   ones_cnt
);
   localparam logic [WIDTH:0] LAST = {1'b0, {WIDTH{1'b1}}};
   state_t           state, state_n;
   logic [2:0]       op_q;
   logic [WIDTH:0]   cnt;
   logic             last_q, sw_q;
   logic             sweeping, free, hs, start, ld_single, ld_sweep, y;
   logic [WIDTH-1:0] sel_a;
   always_comb begin
      sweeping  = state == S_SWEEP;
      free      = !out_valid || out_ready;
      hs        = out_valid && out_ready;
      start     = !sweeping && sweep_start;
      in_ready  = !sweeping && free && !sweep_start;
      ld_single = in_valid && in_ready;
      // cnt[WIDTH] set means every vector has been issued
      ld_sweep  = sweeping && free && !cnt[WIDTH];
      sel_a     = sweeping ? cnt[WIDTH-1:0] : a;
      busy      = sweeping;
      state_n   = start ? S_SWEEP : (sweeping && hs && last_q) ? S_IDLE : state;
   end
   gate_reduce #(.WIDTH(WIDTH)) u_reduce (
      .op (sweeping ? op_q : op),
      .a  (sel_a),
      .y  (y)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q      <= '0;
         cnt       <= '0;
         ones_cnt  <= '0;
         done      <= 1'b0;
         out_valid <= 1'b0;
         x         <= 1'b0;
         vec       <= '0;
         last_q    <= 1'b0;
         sw_q      <= 1'b0;
      end else begin
         done <= sweeping && hs && last_q;
         if (start) begin
            op_q     <= op;
            cnt      <= '0;
            ones_cnt <= '0;
         end else begin
            if (ld_sweep) cnt <= cnt + 1'b1;
            // a single-shot result still draining at sweep entry is not counted
            if (sweeping && hs && x && sw_q) ones_cnt <= ones_cnt + 1'b1;
         end
         if (ld_single || ld_sweep) begin
            out_valid <= 1'b1;
            x         <= y;
            vec       <= sel_a;
            last_q    <= ld_sweep && cnt == LAST;
            sw_q      <= ld_sweep;
         end else if (hs) begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_my_gate_n.sv
// tb_my_gate_n: directed table and sequence checks for my_gate_n at WIDTH=4
module tb_my_gate_n;
   logic       clk = 0, rst = 1;
   logic [2:0] op = 0;
   logic [3:0] a = 0;
   logic       in_valid = 0, sweep_start = 0, out_ready = 1;
   logic       in_ready, x, out_valid, busy, done;
   logic [3:0] vec;
   logic [4:0] ones_cnt;
   int         tests = 0, fails = 0;

   my_gate_n #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst), .op(op), .a(a), .in_valid(in_valid), .in_ready(in_ready),
      .sweep_start(sweep_start), .x(x), .vec(vec), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy), .done(done), .ones_cnt(ones_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] op;
      logic [3:0] a;
      logic       x;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic f(input logic [2:0] o, input logic [3:0] v);
      case (o)
         3'd0: return v == 4'hF;
         3'd1: return v != 4'h0;
         3'd2: return ^v;
         3'd3: return v != 4'hF;
         3'd4: return v == 4'h0;
         3'd5: return ~^v;
         default: return 1'b0;
      endcase
   endfunction

   task automatic check_reset_vals(input string tag);
      chk({tag, "_x"}, int'(x), 0);
      chk({tag, "_vec"}, int'(vec), 0);
      chk({tag, "_out_valid"}, int'(out_valid), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_ones_cnt"}, int'(ones_cnt), 0);
   endtask

   task automatic sweep(input logic [2:0] o, input int exp_ones, input bit rnd, input bit collide);
      int         nexp = 0, cyc = 0;
      bit         got = 0, stall;
      logic [3:0] pv;
      logic       px;
      @(negedge clk);
      op = o; sweep_start = 1; in_valid = collide; a = 4'hF; out_ready = 1;
      #1 chk("start_in_ready", int'(in_ready), 0);
      @(posedge clk); #1;
      chk("start_busy", int'(busy), 1);
      chk("start_no_operand", int'(out_valid), 0);
      @(negedge clk);
      sweep_start = 0;
      in_valid = 1;
      while (!got && cyc < 300) begin
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         op = 3'(o + 3'(cyc) + 3'd1);
         sweep_start = (cyc == 5);
         #1;
         chk("sweep_in_ready", int'(in_ready), 0);
         stall = out_valid && !out_ready;
         pv = vec;
         px = x;
         if (out_valid && out_ready) begin
            chk("sweep_vec", int'(vec), nexp & 15);
            chk("sweep_x", int'(x), int'(f(o, vec)));
            nexp++;
         end
         @(posedge clk); cyc++; #1;
         if (stall) begin
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_vec", int'(vec), int'(pv));
            chk("stall_x", int'(x), int'(px));
         end
         got = done;
         @(negedge clk);
      end
      in_valid = 0; sweep_start = 0; out_ready = 1; op = o;
      chk("sweep_done_seen", int'(got), 1);
      if (!rnd) chk("sweep_cycles", cyc, 17);
      chk("sweep_count", nexp, 16);
      chk("sweep_ones", int'(ones_cnt), exp_ones);
      chk("sweep_busy_end", int'(busy), 0);
      @(posedge clk); #1;
      chk("done_pulse_one", int'(done), 0);
      chk("ones_hold", int'(ones_cnt), exp_ones);
   endtask

   initial begin
      vec_t tbl[15];
      tbl = '{
         '{3'd0, 4'b0001, 1'b0}, '{3'd0, 4'b1110, 1'b0}, '{3'd0, 4'b1111, 1'b1},
         '{3'd1, 4'b0000, 1'b0}, '{3'd1, 4'b0100, 1'b1}, '{3'd2, 4'b0111, 1'b1},
         '{3'd2, 4'b0110, 1'b0}, '{3'd3, 4'b1111, 1'b0}, '{3'd3, 4'b1011, 1'b1},
         '{3'd4, 4'b0000, 1'b1}, '{3'd4, 4'b1000, 1'b0}, '{3'd5, 4'b0011, 1'b1},
         '{3'd5, 4'b1011, 1'b0}, '{3'd6, 4'b1111, 1'b0}, '{3'd7, 4'b0000, 1'b0}
      };
      #12;
      check_reset_vals("reset");
      @(negedge clk);
      rst = 0;
      #1 chk("reset_in_ready", int'(in_ready), 1);
      foreach (tbl[i]) begin
         @(negedge clk);
         op = tbl[i].op; a = tbl[i].a; in_valid = 1; out_ready = 1;
         #1 chk("single_in_ready", int'(in_ready), 1);
         @(posedge clk); #1;
         chk("single_valid", int'(out_valid), 1);
         chk("single_x", int'(x), int'(tbl[i].x));
         chk("single_vec", int'(vec), int'(tbl[i].a));
      end
      @(negedge clk);
      in_valid = 0;
      sweep(3'd0, 1, 0, 1);
      sweep(3'd2, 8, 0, 0);
      sweep(3'd3, 15, 1, 0);
      sweep(3'd4, 1, 1, 1);
      sweep(3'd1, 15, 1, 0);
      sweep(3'd5, 8, 0, 0);
      @(negedge clk);
      op = 3'd3; sweep_start = 1;
      @(negedge clk);
      sweep_start = 0;
      repeat (6) @(posedge clk);
      #2 rst = 1;
      #1 check_reset_vals("midsweep_reset");
      @(negedge clk);
      rst = 0;
      #1 chk("midsweep_in_ready", int'(in_ready), 1);
      @(posedge clk); #1;
      chk("midsweep_idle", int'(busy), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
